mem_copy_dma: RTL and testbench
===============================

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: word-address width, matching RAM depth 2**10.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle copy request, honoured only in IDLE.
REQ-006 SHALL have port abort, input, 1: stop the copy at the next word boundary.
REQ-007 SHALL have port src_addr, input, ADDR_WIDTH: first source word address, sampled on accepted start.
REQ-008 SHALL have port dst_addr, input, ADDR_WIDTH: first destination word address, sampled on accepted start.
REQ-009 SHALL have port length, input, ADDR_WIDTH+1: word count, 0..2**ADDR_WIDTH, sampled on accepted start.
REQ-010 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-011 SHALL have port done, output, 1: one-cycle pulse when a copy completes or aborts.
REQ-012 SHALL have port aborted, output, 1: qualifies done; high when the copy ended by abort; held until the next accepted start.
REQ-013 SHALL have port words_done, output, ADDR_WIDTH+1: number of destination writes accepted in the current or last copy.
REQ-014 SHALL have port data_addr, output, ADDR_WIDTH: memory word address to the ram_cache-side data port.
REQ-015 SHALL have port read_m, output, 1: read request.
REQ-016 SHALL have port write_m, output, 1: write request.
REQ-017 SHALL have port out_m, output, DATA_WIDTH: write data.
REQ-018 SHALL have port in_m, input, DATA_WIDTH: read data.
REQ-019 SHALL have port stall, input, 1: responder not ready; a request asserted while stall=1 is not accepted.

Function
REQ-020 SHALL act as the initiator on the data-port protocol: a request is accepted in the cycle where read_m or write_m is 1 and stall=0.
REQ-021 SHALL hold read_m, write_m, data_addr and out_m stable from the first request cycle until acceptance, and SHALL never withdraw a request before it is accepted.
REQ-022 SHALL never assert read_m and write_m in the same cycle.
REQ-023 SHALL take read data from in_m in the cycle after read acceptance and latch it in an internal data register.
REQ-024 SHALL implement the states IDLE, RD, CAP, WR and FIN.
REQ-025 In IDLE, start=1 SHALL latch the source address, destination address and length, clear words_done and aborted, and go to RD; if length=0 it SHALL go to FIN instead.
REQ-026 In RD, the state machine SHALL drive read_m=1 with data_addr=src; on acceptance it SHALL go to CAP.
REQ-027 In CAP, the state machine SHALL latch in_m into the data register and go to WR; no request is driven in CAP.
REQ-028 In WR, the state machine SHALL drive write_m=1 with data_addr=dst and out_m=data register.
REQ-029 On acceptance in WR, the block SHALL increment src, dst and words_done.
REQ-030 After a WR acceptance, the block SHALL go to FIN if words_done+1 equals length or abort is pending; otherwise it SHALL go to RD.
REQ-031 In FIN, the block SHALL pulse done=1 for one cycle and go to IDLE.
REQ-032 With stall=0 throughout, the block SHALL complete each word in 3 cycles (RD, CAP, WR); an N-word copy SHALL make done high in cycle 3N+1 after the start cycle, where the start cycle is cycle 0 and N>0.
REQ-033 The src and dst address increments SHALL wrap modulo 2**ADDR_WIDTH.
REQ-034 Overlapping source and destination regions SHALL be copied in ascending order with no hazard protection.
REQ-035 The block SHALL register abort into a pending flag while busy; the word in flight SHALL finish its write.
REQ-036 When a copy ends with the abort flag pending, the block SHALL set aborted=1.
REQ-037 An abort asserted in the same cycle as the final WR acceptance SHALL end the copy with done=1 and aborted=0.
REQ-038 The block SHALL ignore start while busy, and SHALL ignore abort in IDLE.
REQ-039 In IDLE and FIN, outputs SHALL be read_m=0 and write_m=0, and data_addr and out_m SHALL hold their last values.

Reset
REQ-040 reset=1 SHALL force IDLE on the next edge, with busy=0, done=0, aborted=0, read_m=0, write_m=0, words_done=0, data_addr=0 and out_m=0.
REQ-041 reset mid-copy SHALL drop any outstanding request immediately, with no completion pulse.
REQ-042 reset SHALL take priority over start and abort.

Verification
REQ-043 The bench SHALL check: src=0x010, dst=0x200, length=4, stall=0, RAM[0x10..0x13]=A0,A1,A2,A3 -> RAM[0x200..0x203]=A0..A3; done in cycle 13; words_done=4; aborted=0.
REQ-044 The bench SHALL check: stall high for 3 cycles on every request -> requests are held stable, each word takes 9 cycles, and the data is correct.
REQ-045 The bench SHALL check: src=0x3FE, dst=0x100, length=4 -> reads 0x3FE, 0x3FF, 0x000, 0x001 in order.
REQ-046 The bench SHALL check: length=0 -> no read_m or write_m is asserted, and done pulses in cycle 1.
REQ-047 The bench SHALL check: length=8 with abort during the CAP state of word 3 -> exactly 3 writes, done=1, aborted=1, words_done=3.
REQ-048 The bench SHALL check: reset asserted during WR under stall -> write_m=0 next cycle, no done, and a following start copies correctly.

Source files
------------

// File: rtl/mem_copy_dma.sv
// Word-by-word memory copy engine: reads a source word, writes it to the destination, repeats.
// Acts as initiator on a request/accept data port where stall=1 holds off acceptance.
module mem_copy_dma #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   length,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [ADDR_WIDTH:0]   words_done,
   output logic [ADDR_WIDTH-1:0] data_addr,
   output logic                  read_m,
   output logic                  write_m,
   output logic [DATA_WIDTH-1:0] out_m,
   input  logic [DATA_WIDTH-1:0] in_m,
   input  logic                  stall
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_FIN  = 3'd4
   } state_t;

   state_t                  state_r, state_nxt_s;
   logic [ADDR_WIDTH-1:0]   src_r, src_nxt_s;
   logic [ADDR_WIDTH-1:0]   dst_r, dst_nxt_s;
   logic [ADDR_WIDTH:0]     len_r, len_nxt_s;
   logic [ADDR_WIDTH:0]     words_r, words_nxt_s;
   logic [DATA_WIDTH-1:0]   data_r, data_nxt_s;
   logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s;
   logic                    abort_pend_r, abort_pend_nxt_s;
   logic                    aborted_r, aborted_nxt_s;
   logic                    busy_r, done_r, read_r, write_r;
   logic                    start_acc_s, wr_acc_s, last_s;

   assign start_acc_s = (state_r == S_IDLE) && start;
   assign wr_acc_s    = (state_r == S_WR) && !stall;
   assign last_s      = ((words_r + CNT_ONE) == len_r);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; the abort flag is only consulted after a write is accepted
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_nxt_s = (length == CNT_ZERO) ? S_FIN : S_RD;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RD: begin
            if (!stall) begin
               state_nxt_s = S_CAP;
            end else begin
               state_nxt_s = S_RD;
            end
         end
         S_CAP:   state_nxt_s = S_WR;
         S_WR: begin
            if (!stall) begin
               state_nxt_s = (last_s || abort_pend_r) ? S_FIN : S_RD;
            end else begin
               state_nxt_s = S_WR;
            end
         end
         S_FIN:   state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Next values of the datapath and of the registered port outputs
   always_comb begin
      if (start_acc_s) begin
         src_nxt_s   = src_addr;
         dst_nxt_s   = dst_addr;
         len_nxt_s   = length;
         words_nxt_s = CNT_ZERO;
      end else if (wr_acc_s) begin
         src_nxt_s   = src_r + ADDR_ONE;
         dst_nxt_s   = dst_r + ADDR_ONE;
         len_nxt_s   = len_r;
         words_nxt_s = words_r + CNT_ONE;
      end else begin
         src_nxt_s   = src_r;
         dst_nxt_s   = dst_r;
         len_nxt_s   = len_r;
         words_nxt_s = words_r;
      end

      if (start_acc_s) begin
         abort_pend_nxt_s = 1'b0;
      end else if ((state_r != S_IDLE) && abort) begin
         abort_pend_nxt_s = 1'b1;
      end else begin
         abort_pend_nxt_s = abort_pend_r;
      end

      if (start_acc_s) begin
         aborted_nxt_s = 1'b0;
      end else if (wr_acc_s && (state_nxt_s == S_FIN)) begin
         aborted_nxt_s = abort_pend_r;
      end else begin
         aborted_nxt_s = aborted_r;
      end

      if (state_r == S_CAP) begin
         data_nxt_s = in_m;
      end else begin
         data_nxt_s = data_r;
      end

      // Address follows the state being entered so it is valid with the request
      case (state_nxt_s)
         S_RD:    addr_nxt_s = src_nxt_s;
         S_WR:    addr_nxt_s = dst_nxt_s;
         default: addr_nxt_s = addr_r;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         src_r        <= ADDR_ZERO;
         dst_r        <= ADDR_ZERO;
         len_r        <= CNT_ZERO;
         words_r      <= CNT_ZERO;
         data_r       <= DATA_ZERO;
         addr_r       <= ADDR_ZERO;
         abort_pend_r <= 1'b0;
         aborted_r    <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         read_r       <= 1'b0;
         write_r      <= 1'b0;
      end else begin
         src_r        <= src_nxt_s;
         dst_r        <= dst_nxt_s;
         len_r        <= len_nxt_s;
         words_r      <= words_nxt_s;
         data_r       <= data_nxt_s;
         addr_r       <= addr_nxt_s;
         abort_pend_r <= abort_pend_nxt_s;
         aborted_r    <= aborted_nxt_s;
         busy_r       <= (state_nxt_s != S_IDLE);
         done_r       <= (state_nxt_s == S_FIN);
         read_r       <= (state_nxt_s == S_RD);
         write_r      <= (state_nxt_s == S_WR);
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign aborted    = aborted_r;
   assign words_done = words_r;
   assign data_addr  = addr_r;
   assign read_m     = read_r;
   assign write_m    = write_r;
   assign out_m      = data_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: behavioural RAM responder with configurable stall,
// and an array-level copy model that predicts the final memory image.
module tb_mem_copy_dma;

   localparam int AW = 10;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, aborted, read_m, write_m;
   logic [AW:0]   words_done;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] out_m;
   logic [DW-1:0] in_m = '0;
   logic          stall = 1'b0;

   int total = 0;
   int bad = 0;

   logic [DW-1:0] mem     [0:1023];
   logic [DW-1:0] exp_mem [0:1023];
   logic [AW-1:0] rd_log [$];

   int stall_mode = 0;
   int stall_cnt = 0;
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, proto_err = 0, req_seen = 0;
   logic          rd_pend = 1'b0;
   logic [AW-1:0] rd_addr_q = '0;
   logic          prev_hold = 1'b0, prev_reset = 1'b1, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [DW-1:0] prev_out = '0;

   mem_copy_dma #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
      .data_addr(data_addr), .read_m(read_m), .write_m(write_m),
      .out_m(out_m), .in_m(in_m), .stall(stall)
   );

   always #5 clk = ~clk;

   // RAM responder, stall generator and protocol monitor, just after each falling edge
   always begin
      @(negedge clk);
      #1;
      case (stall_mode)
         1: begin
            if (read_m === 1'b1 || write_m === 1'b1) begin
               if (stall_cnt < 3) begin stall = 1'b1; stall_cnt++; end
               else begin stall = 1'b0; stall_cnt = 0; end
            end else begin
               stall = 1'b0; stall_cnt = 0;
            end
         end
         3:       stall = ($urandom_range(0, 2) == 0);
         4:       stall = (write_m === 1'b1);
         default: stall = 1'b0;
      endcase
      if (rd_pend) in_m = mem[rd_addr_q];
      else in_m = DW'($urandom);
      rd_pend = 1'b0;
      if (prev_hold && !prev_reset &&
          (read_m !== prev_rd || write_m !== prev_wr || data_addr !== prev_addr || out_m !== prev_out))
         proto_err++;
      if (read_m === 1'b1 && write_m === 1'b1) proto_err++;
      if (read_m === 1'b1 || write_m === 1'b1) req_seen++;
      if (done === 1'b1) done_cnt++;
      if (read_m === 1'b1 && !stall) begin
         rd_cnt++; rd_log.push_back(data_addr); rd_pend = 1'b1; rd_addr_q = data_addr;
      end
      if (write_m === 1'b1 && !stall) begin
         wr_cnt++; mem[data_addr] = out_m;
      end
      prev_hold  = (read_m === 1'b1 || write_m === 1'b1) && stall;
      prev_rd    = read_m;
      prev_wr    = write_m;
      prev_addr  = data_addr;
      prev_out   = out_m;
      prev_reset = reset;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // Reference: ascending word copy with modulo-1024 addressing
   task automatic model_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n);
      for (int i = 0; i < int'(n); i++)
         exp_mem[(int'(d) + i) % 1024] = exp_mem[(int'(s) + i) % 1024];
   endtask

   function automatic int count_diffs();
      int c = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) c++;
      return c;
   endfunction

   task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                           input int abort_cyc, input int restart_cyc, input int max_cyc,
                           output int done_cyc);
      @(negedge clk);
      src_addr = s; dst_addr = d; length = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      src_addr = AW'($urandom); dst_addr = AW'($urandom); length = (AW+1)'($urandom);
      done_cyc = -1;
      for (int k = 1; k <= max_cyc; k++) begin
         if (done === 1'b1) begin done_cyc = k; break; end
         abort = (k == abort_cyc);
         start = (k == restart_cyc);
         @(negedge clk);
      end
      abort = 1'b0; start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1; abort = 1'b1; length = 11'd5;
      repeat (3) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (aborted !== 1'b0) begin bad++; $display("FAIL reset_aborted: got %b want 0", aborted); end
      total++; if (read_m !== 1'b0) begin bad++; $display("FAIL reset_read_m: got %b want 0", read_m); end
      total++; if (write_m !== 1'b0) begin bad++; $display("FAIL reset_write_m: got %b want 0", write_m); end
      total++; if (words_done !== 11'd0) begin bad++; $display("FAIL reset_words_done: got %0d want 0", words_done); end
      total++; if (data_addr !== 10'd0) begin bad++; $display("FAIL reset_data_addr: got %h want 0", data_addr); end
      total++; if (out_m !== 16'd0) begin bad++; $display("FAIL reset_out_m: got %h want 0", out_m); end
      reset = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int dc, ok, w0;
      for (int i = 0; i < 4; i++) begin
         mem[16 + i] = 16'h00A0 + 16'(i);
         exp_mem[16 + i] = 16'h00A0 + 16'(i);
      end
      model_copy(10'h010, 10'h200, 11'd4);
      rd_log.delete(); w0 = wr_cnt;
      run_copy(10'h010, 10'h200, 11'd4, 0, 0, 100, dc);
      total++; if (dc !== 13) begin bad++; $display("FAIL basic_done_cycle: got %0d want 13", dc); end
      total++; if (words_done !== 11'd4) begin bad++; $display("FAIL basic_words_done: got %0d want 4", words_done); end
      total++; if (aborted !== 1'b0) begin bad++; $display("FAIL basic_aborted: got %b want 0", aborted); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_fin: got %b want 1", busy); end
      @(negedge clk);
      total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL basic_done_pulse: got done,busy=%b want 00", {done, busy}); end
      total++; if (wr_cnt - w0 !== 4) begin bad++; $display("FAIL basic_writes: got %0d want 4", wr_cnt - w0); end
      ok = 0;
      for (int i = 0; i < rd_log.size() && i < 4; i++) if (rd_log[i] === 10'(16 + i)) ok++;
      total++; if (ok !== 4 || rd_log.size() !== 4) begin bad++; $display("FAIL basic_read_order: got %0d matches of %0d want 4 of 4", ok, rd_log.size()); end
      total++; if (mem[10'h203] !== 16'h00A3) begin bad++; $display("FAIL basic_last_word: got %h want 00a3", mem[10'h203]); end
      total++; if (count_diffs() !== 0) begin bad++; $display("FAIL basic_memory: got %0d differing words want 0", count_diffs()); end
   endtask

   task automatic test_stall();
      int dc, n, p0;
      logic [AW-1:0] s;
      stall_mode = 1; p0 = proto_err;
      n = $urandom_range(3, 6); s = AW'($urandom);
      model_copy(s, s + 10'h080, (AW+1)'(n));
      run_copy(s, s + 10'h080, (AW+1)'(n), 0, 0, 200, dc);
      total++; if (dc !== 9 * n + 1) begin bad++; $display("FAIL stall_done_cycle: got %0d want %0d", dc, 9 * n + 1); end
      total++; if (words_done !== (AW+1)'(n)) begin bad++; $display("FAIL stall_words_done: got %0d want %0d", words_done, n); end
      total++; if (proto_err !== p0) begin bad++; $display("FAIL stall_hold_stable: got %0d violations want 0", proto_err - p0); end
      total++; if (count_diffs() !== 0) begin bad++; $display("FAIL stall_memory: got %0d differing words want 0", count_diffs()); end
      stall_mode = 0;
      @(negedge clk);
   endtask

   task automatic test_wrap();
      int dc, ok;
      logic [AW-1:0] e;
      model_copy(10'h3FE, 10'h100, 11'd4);
      rd_log.delete();
      run_copy(10'h3FE, 10'h100, 11'd4, 0, 0, 100, dc);
      e = 10'h3FE; ok = 0;
      for (int i = 0; i < rd_log.size() && i < 4; i++) begin
         if (rd_log[i] === e) ok++;
         e = e + 10'd1;
      end
      total++; if (ok !== 4 || rd_log.size() !== 4) begin bad++; $display("FAIL wrap_read_order: got %0d matches of %0d want 4 of 4", ok, rd_log.size()); end
      total++; if (dc !== 13) begin bad++; $display("FAIL wrap_done_cycle: got %0d want 13", dc); end
      total++; if (count_diffs() !== 0) begin bad++; $display("FAIL wrap_memory: got %0d differing words want 0", count_diffs()); end
      @(negedge clk);
   endtask

   task automatic test_zero();
      int dc, r0;
      r0 = req_seen;
      run_copy(10'h123, 10'h321, 11'd0, 0, 0, 20, dc);
      total++; if (dc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", dc); end
      repeat (2) @(negedge clk);
      total++; if (req_seen !== r0) begin bad++; $display("FAIL zero_no_requests: got %0d request cycles want 0", req_seen - r0); end
      total++; if (words_done !== 11'd0) begin bad++; $display("FAIL zero_words_done: got %0d want 0", words_done); end
   endtask

   task automatic test_abort();
      int dc, w0;
      model_copy(10'h040, 10'h240, 11'd3);
      w0 = wr_cnt;
      run_copy(10'h040, 10'h240, 11'd8, 8, 0, 100, dc);
      total++; if (dc !== 10) begin bad++; $display("FAIL abort_done_cycle: got %0d want 10", dc); end
      total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag: got %b want 1", aborted); end
      total++; if (words_done !== 11'd3) begin bad++; $display("FAIL abort_words_done: got %0d want 3", words_done); end
      repeat (3) @(negedge clk);
      total++; if (wr_cnt - w0 !== 3) begin bad++; $display("FAIL abort_writes: got %0d want 3", wr_cnt - w0); end
      total++; if (aborted !== 1'b1) begin bad++; $display("FAIL abort_flag_held: got %b want 1", aborted); end
      total++; if (count_diffs() !== 0) begin bad++; $display("FAIL abort_memory: got %0d differing words want 0", count_diffs()); end
      model_copy(10'h060, 10'h260, 11'd2);
      run_copy(10'h060, 10'h260, 11'd2, 6, 0, 100, dc);
      total++; if (dc !== 7) begin bad++; $display("FAIL abort_last_done_cycle: got %0d want 7", dc); end
      total++; if (aborted !== 1'b0) begin bad++; $display("FAIL abort_last_flag: got %b want 0", aborted); end
      total++; if (words_done !== 11'd2) begin bad++; $display("FAIL abort_last_words: got %0d want 2", words_done); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int dc, found, d0, w0;
      stall_mode = 4;
      @(negedge clk);
      src_addr = 10'h050; dst_addr = 10'h060; length = 11'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 20; k++) begin
         if (write_m === 1'b1) begin found = 1; break; end
         @(negedge clk);
      end
      total++; if (found !== 1) begin bad++; $display("FAIL rstmid_reach_wr: got %0d want 1", found); end
      d0 = done_cnt; w0 = wr_cnt;
      reset = 1'b1;
      @(negedge clk);
      total++; if (write_m !== 1'b0) begin bad++; $display("FAIL rstmid_write_drop: got %b want 0", write_m); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      reset = 1'b0; stall_mode = 0;
      repeat (4) @(negedge clk);
      total++; if (done_cnt !== d0) begin bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
      total++; if (wr_cnt !== w0) begin bad++; $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt - w0); end
      model_copy(10'h050, 10'h060, 11'd4);
      run_copy(10'h050, 10'h060, 11'd4, 0, 0, 100, dc);
      total++; if (dc !== 13) begin bad++; $display("FAIL rstmid_recopy_cycle: got %0d want 13", dc); end
      total++; if (count_diffs() !== 0) begin bad++; $display("FAIL rstmid_recopy_memory: got %0d differing words want 0", count_diffs()); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int dc, n, d0, mode;
      logic [AW-1:0] s, d;
      for (int it = 0; it < 8; it++) begin
         mode = (it % 2 == 1) ? 3 : 0;
         stall_mode = mode;
         s = AW'($urandom);
         d = (it % 3 == 0) ? s + AW'(it + 2) : AW'($urandom);
         n = (it == 0) ? 1024 : $urandom_range(1, 12);
         @(negedge clk); abort = 1'b1;
         @(negedge clk); abort = 1'b0;
         d0 = done_cnt;
         model_copy(s, d, (AW+1)'(n));
         run_copy(s, d, (AW+1)'(n), 0, 2, 4000, dc);
         total++;
         if (mode == 0) begin
            if (dc !== 3 * n + 1) begin bad++; $display("FAIL b2b_done_cycle[%0d]: got %0d want %0d", it, dc, 3 * n + 1); end
         end else begin
            if (dc < 0) begin bad++; $display("FAIL b2b_done_seen[%0d]: got timeout want done", it); end
         end
         total++; if (words_done !== (AW+1)'(n)) begin bad++; $display("FAIL b2b_words_done[%0d]: got %0d want %0d", it, words_done, n); end
         total++; if (aborted !== 1'b0) begin bad++; $display("FAIL b2b_aborted[%0d]: got %b want 0", it, aborted); end
         repeat (2) @(negedge clk);
         total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL b2b_done_count[%0d]: got %0d want 1", it, done_cnt - d0); end
         total++; if (count_diffs() !== 0) begin bad++; $display("FAIL b2b_memory[%0d]: got %0d differing words want 0", it, count_diffs()); end
      end
      stall_mode = 0;
      total++; if (proto_err !== 0) begin bad++; $display("FAIL protocol_overall: got %0d violations want 0", proto_err); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i] = DW'($urandom);
         exp_mem[i] = mem[i];
      end
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_zero();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
